// File: rtl/fifo_rd_stream.sv
// Read-side controller for fifo_syn: issues FIFO reads and re-presents the words as a
// valid/ready stream through a 2-entry buffer that hides the FIFO's one-cycle read latency.
module fifo_rd_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_q,
   output logic             fifo_rd,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   input  logic             flush,
   output logic [1:0]       level
);

   logic [1:0]       occ_q, occ_d;
   logic             inflight_q;
   logic [WIDTH-1:0] buf0_q, buf0_d;
   logic [WIDTH-1:0] buf1_q, buf1_d;
   logic             pop;
   logic             arrival;
   logic [2:0]       committed;

   assign m_valid = (occ_q != 2'd0);
   assign m_data  = buf0_q;
   assign level   = occ_q;
   assign pop     = m_valid & m_ready;
   assign arrival = inflight_q;

   // Slots already spoken for after this cycle's pop; a new read needs one free slot.
   assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd   = ~rst & ~flush & ~fifo_empty & (committed < 3'd2);

   always_comb begin
      occ_d  = occ_q;
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      if (flush) begin
         occ_d = 2'd0;
      end else begin
         case ({pop, arrival})
            2'b01: begin
               if (occ_q == 2'd0) buf0_d = fifo_q;
               else               buf1_d = fifo_q;
               occ_d = occ_q + 2'd1;
            end
            2'b10: begin
               buf0_d = buf1_q;
               occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged; the arriving word goes wherever the new tail is.
               if (occ_q == 2'd1) begin
                  buf0_d = fifo_q;
               end else begin
                  buf0_d = buf1_q;
                  buf1_d = fifo_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

endmodule
